data_mem: RTL and testbench

Word-organised data memory with byte-lane write strobes and a fixed, parameterised access latency. It sits directly downstream of the memory-access stage and consumes that stage's address, write-enable, byte-select, store-data and chip-enable outputs. It returns load data and a ready pulse. While an access is in flight it raises a stall request, which holds the pipeline.

---
 rtl/data_mem_pkg.sv | 31 +++
 rtl/data_mem_byte_merge.sv | 18 +
 rtl/data_mem.sv | 135 +++++++++++++
 tb/tb_data_mem.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory: FSM encoding, constants and the
// set of byte-select patterns that count as naturally aligned accesses.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] ZERO32 = 32'h0000_0000;

  // Latency counter width; covers LATENCY-1 for LATENCY up to 8.
  localparam int unsigned CNT_W = 3;

  // Byte, halfword and word patterns that sit on their natural boundary.
  localparam int unsigned N_ALIGNED = 7;
  localparam logic [3:0] ALIGNED_SEL [N_ALIGNED] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
  };

  function automatic logic sel_aligned(input logic [3:0] sel);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < N_ALIGNED; i++) begin
      if (sel == ALIGNED_SEL[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/data_mem_byte_merge.sv
// Byte-lane merge: builds the word to write back from the old word, the
// new store data and the per-lane enables.
module data_mem_byte_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] word_o
);

  // Take each byte from the store data only where its lane is enabled.
  always_comb begin
    word_o = old_i;
    for (int unsigned n = 0; n < 4; n++) begin
      if (sel_i[n]) word_o[8*n +: 8] = new_i[8*n +: 8];
    end
  end

endmodule

// File: rtl/data_mem.sv
// Word-organised data memory with byte strobes and a fixed access latency.
// Optional access-fault output enabled by defining DATA_MEM_ERR_EN.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
`ifdef DATA_MEM_ERR_EN
  output logic        stall_req_o,
  output logic        mem_err_o
`else
  output logic        stall_req_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [29:0]       waddr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       mem_q [DEPTH];
  logic [AW-1:0]     idx;
  logic              in_range;
  logic              sel_ok;
  logic              commit;
  logic              wr_en;
  logic [31:0]       old_word;
  logic [31:0]       merged;

  assign idx      = waddr_q[AW-1:0];
  assign in_range = (waddr_q[29:AW] == '0);
  assign old_word = mem_q[idx];
  assign commit   = (state_q == BUSY) && (cnt_q == '0);

`ifdef DATA_MEM_ERR_EN
  assign sel_ok = sel_aligned(sel_q);
`else
  assign sel_ok = 1'b1;
`endif

  assign wr_en = commit && we_q && in_range && sel_ok;

  data_mem_byte_merge u_byte_merge (
    .old_i  (old_word),
    .new_i  (wdata_q),
    .sel_i  (sel_q),
    .word_o (merged)
  );

  // State, counter and load-data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= ZERO32;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Request latch, taken only when a request is accepted in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      sel_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if ((state_q == IDLE) && mem_ce_i) begin
      we_q    <= mem_we_i;
      sel_q   <= mem_sel_i;
      waddr_q <= mem_addr_i[31:2];
      wdata_q <= mem_data_i;
    end
  end

  // Next-state, counter and load-data selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (mem_ce_i) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          rdata_d = (!we_q && in_range) ? old_word : ZERO32;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Array write; contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx] <= merged;
  end

`ifdef DATA_MEM_ERR_EN
  // Fault flag captured at the access edge so it lines up with ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_err_o <= 1'b0;
    else      mem_err_o <= commit && (!in_range || !sel_ok);
  end
`endif

  assign mem_data_o  = rdata_q;
  assign mem_ready_o = (state_q == RESP);
  assign stall_req_o = ((state_q == IDLE) && mem_ce_i) || (state_q == BUSY);

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: table of accesses plus hand sequences
// for continuous requests and reset during an access.
module tb_data_mem;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 2;

  logic        clk;
  logic        rst;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ready_o;
  logic        stall_req_o;
`ifdef DATA_MEM_ERR_EN
  logic        mem_err_o;
`endif

  data_mem #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_ce_i    (mem_ce_i),
    .mem_we_i    (mem_we_i),
    .mem_sel_i   (mem_sel_i),
    .mem_addr_i  (mem_addr_i),
    .mem_data_i  (mem_data_i),
    .mem_data_o  (mem_data_o),
    .mem_ready_o (mem_ready_o),
`ifdef DATA_MEM_ERR_EN
    .stall_req_o (stall_req_o),
    .mem_err_o   (mem_err_o)
`else
    .stall_req_o (stall_req_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] data;
    bit          err;
    string       name;
  } exp_t;

  exp_t sb[$];

  // Scoreboard: every ready pulse must match the oldest outstanding access.
  always @(negedge clk) begin
    if (rst && mem_ready_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 32'(mem_ready_o), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_data"}, mem_data_o, e.data);
`ifdef DATA_MEM_ERR_EN
        chk({e.name, "_err"}, 32'(mem_err_o), 32'(e.err));
`endif
      end
    end
  end

  typedef struct {
    bit          we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  localparam int unsigned NV = 19;
  vec_t vecs[NV];

`ifdef DATA_MEM_ERR_EN
  localparam bit          ERR_ON  = 1'b1;
  localparam logic [31:0] W10_FIN = 32'hDEADBEAA;
`else
  localparam bit          ERR_ON  = 1'b0;
  localparam logic [31:0] W10_FIN = 32'hDEFFFFAA;
`endif

  // Issue one access at the current cycle (called just after a rising edge
  // with the DUT in IDLE) and wait, bounded, for its ready pulse.
  task automatic run_access(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] exp_data,
                            input bit exp_err, input string name);
    int n;
    sb.push_back('{exp_data, exp_err, name});
    mem_ce_i   = 1'b1;
    mem_we_i   = we;
    mem_sel_i  = sel;
    mem_addr_i = addr;
    mem_data_i = data;
    #1;
    chk({name, "_stall_req"}, 32'(stall_req_o), 32'd1);
    @(posedge clk);
    #1;
    // Garbage on the request inputs while BUSY must be ignored.
    mem_ce_i   = 1'b0;
    mem_we_i   = 1'($urandom);
    mem_sel_i  = 4'($urandom);
    mem_addr_i = $urandom;
    mem_data_i = $urandom;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mem_ready_o) begin
        n = i;
        break;
      end
      chk({name, "_stall_busy"}, 32'(stall_req_o), 32'd1);
    end
    if (n == 0) n = 11;
    chk({name, "_latency"}, 32'(n), 32'(LATENCY + 1));
    chk({name, "_stall_resp"}, 32'(stall_req_o), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'b1111, 32'h0000_0000, 32'h1212_1212, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 4'b1111, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 4'b0001, 32'h0000_0010, 32'h0000_00AA, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 4'b1111, 32'h0000_0010, 32'h0,         32'hDEAD_BEAA, 1'b0};
    vecs[5]  = '{1'b1, 4'b1111, 32'h0000_0020, 32'h1122_3344, 32'h0, 1'b0};
    vecs[6]  = '{1'b1, 4'b1100, 32'h0000_0020, 32'hAABB_CCDD, 32'h0, 1'b0};
    vecs[7]  = '{1'b1, 4'b0010, 32'h0000_0020, 32'h0000_5500, 32'h0, 1'b0};
    vecs[8]  = '{1'b0, 4'b1111, 32'h0000_0020, 32'h0,         32'hAABB_5544, 1'b0};
    vecs[9]  = '{1'b1, 4'b0000, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0, 1'b1};
    vecs[10] = '{1'b0, 4'b1111, 32'h0000_0010, 32'h0,         32'hDEAD_BEAA, 1'b0};
    vecs[11] = '{1'b0, 4'b1111, DEPTH * 4,     32'h0,         32'h0, 1'b1};
    vecs[12] = '{1'b1, 4'b1111, DEPTH * 4,     32'h5555_5555, 32'h0, 1'b1};
    vecs[13] = '{1'b0, 4'b1111, 32'h0000_0000, 32'h0,         32'h1212_1212, 1'b0};
    vecs[14] = '{1'b1, 4'b0110, 32'h0000_0010, 32'h00FF_FF00, 32'h0, ERR_ON};
    vecs[15] = '{1'b0, 4'b1111, 32'h0000_0010, 32'h0,         W10_FIN, 1'b0};
    vecs[16] = '{1'b1, 4'b1111, DEPTH * 4 - 4, 32'h0BAD_F00D, 32'h0, 1'b0};
    vecs[17] = '{1'b0, 4'b1111, DEPTH * 4 - 4, 32'h0,         32'h0BAD_F00D, 1'b0};
    vecs[18] = '{1'b0, 4'b1111, 32'hFFFF_FFFC, 32'h0,         32'h0, 1'b1};

    rst        = 1'b0;
    mem_ce_i   = 1'b0;
    mem_we_i   = 1'b0;
    mem_sel_i  = '0;
    mem_addr_i = '0;
    mem_data_i = '0;

    repeat (2) @(negedge clk);
    chk("reset_data", mem_data_o, 32'h0);
    chk("reset_ready", 32'(mem_ready_o), 32'd0);
    chk("reset_stall", 32'(stall_req_o), 32'd0);
`ifdef DATA_MEM_ERR_EN
    chk("reset_err", 32'(mem_err_o), 32'd0);
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_no_ce_stall", 32'(stall_req_o), 32'd0);

    for (int i = 0; i < int'(NV); i++) begin
      run_access(vecs[i].we, vecs[i].sel, vecs[i].addr, vecs[i].data,
                 vecs[i].exp_data, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Request held high: ready every LATENCY+2 cycles, stall low only in RESP.
    for (int r = 0; r < 3; r++) sb.push_back('{W10_FIN, 1'b0, $sformatf("cont%0d", r)});
    mem_ce_i   = 1'b1;
    mem_we_i   = 1'b0;
    mem_sel_i  = 4'b1111;
    mem_addr_i = 32'h10;
    for (int k = 0; k < 3 * int'(LATENCY + 2); k++) begin
      @(negedge clk);
      chk($sformatf("cont_stall_k%0d", k), 32'(stall_req_o),
          32'((k % int'(LATENCY + 2)) != int'(LATENCY + 1)));
      chk($sformatf("cont_ready_k%0d", k), 32'(mem_ready_o),
          32'((k % int'(LATENCY + 2)) == int'(LATENCY + 1)));
    end
    @(posedge clk);
    #1;
    mem_ce_i = 1'b0;

    // Reset one cycle into BUSY of a store: dropped, no ready, outputs cleared.
    mem_ce_i   = 1'b1;
    mem_we_i   = 1'b1;
    mem_sel_i  = 4'b1111;
    mem_addr_i = 32'h20;
    mem_data_i = 32'h1234_5678;
    @(posedge clk);
    #1;
    mem_ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_data", mem_data_o, 32'h0);
    chk("rst_mid_stall", 32'(stall_req_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_ready%0d", k), 32'(mem_ready_o), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_access(1'b0, 4'b1111, 32'h20, 32'h0, 32'hAABB_5544, 1'b0, "after_rst_load");

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
